// File: rtl/mem_lsu_stage.sv
// MEM-stage load/store unit: single-outstanding word bus master with byte enables,
// load extraction/extension, misalignment and fault reporting, plus branch resolution.
module mem_lsu_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_memAddr,
    input  logic [31:0]       i_wrData,
    input  logic              i_memRead,
    input  logic              i_memWrite,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic              i_branch,
    input  logic              i_jump,
    input  logic [2:0]        i_brCond,
    input  logic              i_zero,
    input  logic              i_lt,
    input  logic              i_ltu,
    output logic              o_PCSrc,
    output logic              o_stall,
    output logic [31:0]       o_readData,
    output logic              o_rdValid,
    output logic              o_misaligned,
    output logic              o_fault,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [31:0]       o_bus_wdata,
    output logic [3:0]        o_bus_be,
    input  logic              i_bus_ack,
    input  logic              i_bus_err,
    input  logic [31:0]       i_bus_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    logic [1:0]        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              load_q;
    logic              uns_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic [31:0]       rdata_q;
    logic              mis_q;
    logic              fault_q;

    logic              access;
    logic              aligned;
    logic [3:0]        be_nxt;
    logic [31:0]       wdata_nxt;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;
    logic              timeout_hit;
    logic              cond_met;

    assign access = i_valid & (i_memRead | i_memWrite);

    always_comb begin
        aligned   = 1'b0;
        be_nxt    = 4'b1111;
        wdata_nxt = i_wrData;
        case (i_size)
            2'b00: begin
                aligned   = 1'b1;
                be_nxt    = 4'b0001 << i_memAddr[1:0];
                wdata_nxt = {4{i_wrData[7:0]}};
            end
            2'b01: begin
                aligned   = ~i_memAddr[0];
                be_nxt    = 4'b0011 << i_memAddr[1:0];
                wdata_nxt = {2{i_wrData[15:0]}};
            end
            2'b10:   aligned = (i_memAddr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    // Extraction works off the attributes latched at accept, not the live inputs
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = i_bus_rdata[7:0];
            2'd1:    byte_sel = i_bus_rdata[15:8];
            2'd2:    byte_sel = i_bus_rdata[23:16];
            default: byte_sel = i_bus_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_ext = i_bus_rdata;
        endcase
    end

    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            load_q  <= 1'b0;
            uns_q   <= 1'b0;
            lane_q  <= '0;
            size_q  <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        load_q  <= i_memRead;
                        fault_q <= 1'b0;
                        rdata_q <= '0;
                        if (aligned) begin
                            addr_q  <= {i_memAddr[ADDR_W-1:2], 2'b00};
                            be_q    <= be_nxt;
                            wdata_q <= wdata_nxt;
                            we_q    <= ~i_memRead;
                            lane_q  <= i_memAddr[1:0];
                            size_q  <= i_size;
                            uns_q   <= i_unsigned;
                            cnt_q   <= '0;
                            mis_q   <= 1'b0;
                            state_q <= ST_BUS;
                        end else begin
                            mis_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_BUS: begin
                    if (i_bus_err) begin
                        fault_q <= 1'b1;
                        rdata_q <= '0;
                        state_q <= ST_DONE;
                    end else if (i_bus_ack) begin
                        rdata_q <= load_q ? load_ext : '0;
                        state_q <= ST_DONE;
                    end else if (timeout_hit) begin
                        fault_q <= 1'b1;
                        rdata_q <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (i_brCond)
            3'b000:  cond_met = i_zero;
            3'b001:  cond_met = ~i_zero;
            3'b100:  cond_met = i_lt;
            3'b101:  cond_met = ~i_lt;
            3'b110:  cond_met = i_ltu;
            3'b111:  cond_met = ~i_ltu;
            default: cond_met = 1'b0;
        endcase
    end

    assign o_PCSrc      = i_valid & (i_jump | (i_branch & cond_met));
    assign o_stall      = ((state_q == ST_IDLE) & access) | (state_q == ST_BUS);
    assign o_bus_req    = (state_q == ST_BUS);
    assign o_bus_we     = (state_q == ST_BUS) & we_q;
    assign o_bus_addr   = addr_q;
    assign o_bus_wdata  = wdata_q;
    assign o_bus_be     = be_q;
    assign o_readData   = rdata_q;
    assign o_rdValid    = (state_q == ST_DONE) & load_q;
    assign o_misaligned = (state_q == ST_DONE) & mis_q;
    assign o_fault      = (state_q == ST_DONE) & fault_q;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Bench for mem_lsu_stage: directed vector table, hand sequences for reset/stray
// responses/branches, and randomized accesses checked against an arithmetic model.
module tb_mem_lsu_stage;

    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_valid;
    logic [31:0] i_memAddr;
    logic [31:0] i_wrData;
    logic        i_memRead;
    logic        i_memWrite;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic        i_branch;
    logic        i_jump;
    logic [2:0]  i_brCond;
    logic        i_zero;
    logic        i_lt;
    logic        i_ltu;
    logic        o_PCSrc;
    logic        o_stall;
    logic [31:0] o_readData;
    logic        o_rdValid;
    logic        o_misaligned;
    logic        o_fault;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_ack;
    logic        i_bus_err;
    logic [31:0] i_bus_rdata;

    mem_lsu_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_memAddr(i_memAddr),
        .i_wrData(i_wrData), .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_size(i_size),
        .i_unsigned(i_unsigned), .i_branch(i_branch), .i_jump(i_jump), .i_brCond(i_brCond),
        .i_zero(i_zero), .i_lt(i_lt), .i_ltu(i_ltu), .o_PCSrc(o_PCSrc), .o_stall(o_stall),
        .o_readData(o_readData), .o_rdValid(o_rdValid), .o_misaligned(o_misaligned),
        .o_fault(o_fault), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be), .i_bus_ack(i_bus_ack),
        .i_bus_err(i_bus_err), .i_bus_rdata(i_bus_rdata)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wd;
        logic [31:0] rdat;
        int          waits;   // ack after this many wait cycles; -1 = never ack
        logic        err;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[16];

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_valid = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0; i_size = 2'b00;
        i_unsigned = 1'b0; i_memAddr = '0; i_wrData = '0; i_bus_ack = 1'b0;
        i_bus_err = 1'b0; i_bus_rdata = '0; i_branch = 1'b0; i_jump = 1'b0;
        i_brCond = 3'b000; i_zero = 1'b0; i_lt = 1'b0; i_ltu = 1'b0;
    endtask

    // Reference derived from the access rules with plain arithmetic
    task automatic ref_model(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                             input logic [31:0] wd, input logic [31:0] rdat,
                             output logic mis, output logic [3:0] be,
                             output logic [31:0] bwd, output logic [31:0] rd);
        int unsigned off, nbytes, shift;
        logic [31:0] mask, raw, topbit;
        off    = addr % 4;
        mis    = !(size == 2'd0 || (size == 2'd1 && off % 2 == 0) || (size == 2'd2 && off == 0));
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        be     = (nbytes == 4) ? 4'hF : 4'(((1 << nbytes) - 1) << off);
        bwd    = (size == 2'd0) ? (wd & 32'hFF) * 32'h01010101 :
                 (size == 2'd1) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        shift  = (size == 2'd0) ? 8 * off : (size == 2'd1) ? 16 * (off / 2) : 0;
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nbytes)) - 32'd1;
        raw    = (rdat >> shift) & mask;
        topbit = (mask >> 1) + 32'd1;
        rd     = (!uns && nbytes < 4 && (raw & topbit) != 0) ? (raw | ~mask) : raw;
    endtask

    // Starts in the IDLE cycle after the current one; ends sampled in the DONE cycle
    task automatic run_txn(input string tag, input vec_t v);
        int   s;
        logic exp_fault;
        logic in_bus;
        exp_fault = !v.exp_mis && (v.err || v.waits < 0);
        s = v.exp_mis ? 1 : ((v.waits < 0) ? TO + 1 : v.waits + 2);
        next_cycle();
        i_valid = 1'b1; i_memRead = v.rd; i_memWrite = v.wr; i_memAddr = v.addr;
        i_size = v.size; i_unsigned = v.uns; i_wrData = v.wd; i_bus_rdata = v.rdat;
        for (int c = 0; c <= s; c++) begin
            if (c > 0) next_cycle();
            in_bus    = !v.exp_mis && c >= 1 && c < s;
            i_bus_ack = in_bus && v.waits >= 0 && (c - 1 == v.waits);
            i_bus_err = i_bus_ack && v.err;
            #1;
            check1($sformatf("%s stall c%0d", tag, c), o_stall, c < s);
            check1($sformatf("%s req c%0d", tag, c), o_bus_req, in_bus);
            if (in_bus) begin
                check32($sformatf("%s addr", tag), o_bus_addr, v.addr & 32'hFFFF_FFFC);
                check32($sformatf("%s be", tag), {28'd0, o_bus_be}, {28'd0, v.exp_be});
                check32($sformatf("%s wdata", tag), o_bus_wdata, v.exp_wd);
                check1($sformatf("%s we", tag), o_bus_we, v.wr && !v.rd);
            end
            if (c == s) begin
                check1($sformatf("%s rdValid", tag), o_rdValid, v.rd);
                check1($sformatf("%s misaligned", tag), o_misaligned, v.exp_mis);
                check1($sformatf("%s fault", tag), o_fault, exp_fault);
                if (v.rd)
                    check32($sformatf("%s readData", tag), o_readData,
                            (v.exp_mis || exp_fault) ? 32'd0 : v.exp_rd);
            end else begin
                check1($sformatf("%s rdValid c%0d", tag, c), o_rdValid, 1'b0);
                check1($sformatf("%s misaligned c%0d", tag, c), o_misaligned, 1'b0);
                check1($sformatf("%s fault c%0d", tag, c), o_fault, 1'b0);
            end
        end
        clear_inputs();
    endtask

    function automatic logic br_ref(input logic [2:0] cond, input logic z, input logic lt,
                                    input logic ltu);
        case (cond)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return lt;
            3'd5:    return !lt;
            3'd6:    return ltu;
            3'd7:    return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        vec_t v;
        logic [3:0] rsel;

        //            rd    wr    addr          sz    uns   wd            rdat          w   err   mis   be     wd            rd
        tbl[0]  = '{1'b1, 1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 0,  1'b0, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0103, 2'd0, 1'b0, 32'h0,        32'h80FF0000, 1,  1'b0, 1'b0, 4'h8, 32'h0,        32'hFFFFFF80};
        tbl[2]  = '{1'b1, 1'b0, 32'h0000_0103, 2'd0, 1'b1, 32'h0,        32'h80FF0000, 0,  1'b0, 1'b0, 4'h8, 32'h0,        32'h00000080};
        tbl[3]  = '{1'b1, 1'b0, 32'h0000_0102, 2'd1, 1'b0, 32'h0,        32'h80FF0000, 0,  1'b0, 1'b0, 4'hC, 32'h0,        32'hFFFF80FF};
        tbl[4]  = '{1'b0, 1'b1, 32'h0000_0102, 2'd1, 1'b0, 32'h1234ABCD, 32'h0,        0,  1'b0, 1'b0, 4'hC, 32'hABCDABCD, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0000_0101, 2'd2, 1'b0, 32'h0,        32'h0,        0,  1'b0, 1'b1, 4'hF, 32'h0,        32'h0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0000_0200, 2'd2, 1'b0, 32'h0,        32'h55AA55AA, 1,  1'b1, 1'b0, 4'hF, 32'h0,        32'h0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0000_0300, 2'd2, 1'b0, 32'h0,        32'h0,        -1, 1'b0, 1'b0, 4'hF, 32'h0,        32'h0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0000_0304, 2'd2, 1'b0, 32'h0,        32'h13579BDF, 3,  1'b0, 1'b0, 4'hF, 32'h0,        32'h13579BDF};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_0100, 2'd3, 1'b0, 32'h0,        32'h0,        0,  1'b0, 1'b1, 4'hF, 32'h0,        32'h0};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_0401, 2'd0, 1'b0, 32'h123456A5, 32'h0,        2,  1'b0, 1'b0, 4'h2, 32'hA5A5A5A5, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h0000_0101, 2'd1, 1'b0, 32'h0,        32'h0,        0,  1'b0, 1'b1, 4'h6, 32'h0,        32'h0};
        tbl[12] = '{1'b1, 1'b1, 32'h0000_0104, 2'd2, 1'b0, 32'h11111111, 32'hCAFEF00D, 0,  1'b0, 1'b0, 4'hF, 32'h11111111, 32'hCAFEF00D};
        tbl[13] = '{1'b0, 1'b1, 32'h0000_0200, 2'd3, 1'b0, 32'h0,        32'h0,        0,  1'b0, 1'b1, 4'hF, 32'h0,        32'h0};
        tbl[14] = '{1'b0, 1'b1, 32'h0000_0003, 2'd1, 1'b0, 32'h0,        32'h0,        0,  1'b0, 1'b1, 4'hC, 32'h0,        32'h0};
        tbl[15] = '{1'b1, 1'b0, 32'h0000_0001, 2'd0, 1'b0, 32'h0,        32'h0000F500, 0,  1'b0, 1'b0, 4'h2, 32'h0,        32'hFFFFFFF5};

        clear_inputs();
        i_reset_n = 1'b0;
        #2;
        check1("rst stall", o_stall, 1'b0);
        check1("rst req", o_bus_req, 1'b0);
        check1("rst we", o_bus_we, 1'b0);
        check1("rst rdValid", o_rdValid, 1'b0);
        check1("rst misaligned", o_misaligned, 1'b0);
        check1("rst fault", o_fault, 1'b0);
        check1("rst PCSrc", o_PCSrc, 1'b0);
        check32("rst readData", o_readData, 32'd0);
        check32("rst addr", o_bus_addr, 32'd0);
        check32("rst wdata", o_bus_wdata, 32'd0);
        check32("rst be", {28'd0, o_bus_be}, 32'd0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_reset_n = 1'b1;

        for (int i = 0; i < 16; i++) run_txn($sformatf("row%0d", i), tbl[i]);

        // Stray responses while idle must be ignored
        next_cycle();
        i_bus_ack = 1'b1; i_bus_err = 1'b1;
        next_cycle();
        #1;
        check1("stray stall", o_stall, 1'b0);
        check1("stray req", o_bus_req, 1'b0);
        check1("stray fault", o_fault, 1'b0);
        check1("stray rdValid", o_rdValid, 1'b0);
        clear_inputs();
        next_cycle();
        #1;
        check1("stray fault2", o_fault, 1'b0);
        check1("stray rdValid2", o_rdValid, 1'b0);

        // Reset while the bus is busy abandons the access; PCSrc ignores the FSM
        next_cycle();
        i_valid = 1'b1; i_memRead = 1'b1; i_memAddr = 32'h500; i_size = 2'd2; i_jump = 1'b1;
        #1;
        check1("midrst accept stall", o_stall, 1'b1);
        check1("midrst PCSrc idle", o_PCSrc, 1'b1);
        next_cycle();
        #1;
        check1("midrst req", o_bus_req, 1'b1);
        check1("midrst PCSrc bus", o_PCSrc, 1'b1);
        i_valid = 1'b0; i_jump = 1'b0;
        #1 i_reset_n = 1'b0;
        #1;
        check1("midrst req dropped", o_bus_req, 1'b0);
        check1("midrst stall", o_stall, 1'b0);
        check32("midrst addr", o_bus_addr, 32'd0);
        #1 i_reset_n = 1'b1;
        clear_inputs();
        run_txn("postrst", tbl[0]);

        // Branch resolution sweep
        for (int cond = 0; cond < 8; cond++)
            for (int fl = 0; fl < 8; fl++)
                for (int ctl = 0; ctl < 8; ctl++) begin
                    i_brCond = 3'(cond);
                    i_zero = fl[0]; i_lt = fl[1]; i_ltu = fl[2];
                    i_valid = ctl[0]; i_branch = ctl[1]; i_jump = ctl[2];
                    #1;
                    check1($sformatf("br cond%0d fl%0d ctl%0d", cond, fl, ctl), o_PCSrc,
                           ctl[0] && (ctl[2] || (ctl[1] && br_ref(3'(cond), fl[0], fl[1], fl[2]))));
                end
        clear_inputs();

        // Randomized accesses against the reference model
        for (int n = 0; n < 250; n++) begin
            rsel   = 4'($urandom_range(0, 2));
            v.rd   = (rsel != 4'd1);
            v.wr   = (rsel != 4'd0);
            v.addr = $urandom;
            v.size = 2'($urandom_range(0, 3));
            v.uns  = 1'($urandom_range(0, 1));
            v.wd   = $urandom;
            v.rdat = $urandom;
            v.waits = $urandom_range(0, 3);
            v.err  = ($urandom_range(0, 7) == 0);
            ref_model(v.addr, v.size, v.uns, v.wd, v.rdat, v.exp_mis, v.exp_be, v.exp_wd, v.exp_rd);
            run_txn($sformatf("rnd%0d", n), v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu_stage.md
# mem_lsu_stage

Parametrised MEM-stage load/store unit and branch resolver for the wizardCore pipeline. It sits between EX/MEM and MEM/WB. It turns MEM-stage control into single-outstanding requests on a word-addressed data bus with byte enables, and extracts and extends load data. It stalls the pipeline while the bus is busy, flags misaligned accesses and bus faults, and resolves all six RV32I branch conditions plus jumps into `o_PCSrc`.

## Interface
- `ADDR_W`, 32, byte-address width.
- `TIMEOUT_CYCLES`, 64, maximum BUS-state cycles without ack before a fault; 0 disables the timeout.
- `i_clk` in 1: clock.
- `i_reset_n` in 1: one clock; reset is asynchronous and active-low.
- `i_valid` in 1: MEM-stage instruction valid.
- `i_memAddr` in ADDR_W: byte address.
- `i_wrData` in 32: store data, right-aligned.
- `i_memRead`, `i_memWrite` in 1: load or store.
- `i_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `i_unsigned` in 1: zero-extend the load.
- `i_branch`, `i_jump` in 1: branch or jump control.
- `i_brCond` in 3: branch funct3.
- `i_zero`, `i_lt`, `i_ltu` in 1: ALU flags (equal, signed less-than, unsigned less-than).
- `o_PCSrc` out 1: take the branch or jump target.
- `o_stall` out 1: hold the MEM stage and everything upstream.
- `o_readData` out 32: extended load data.
- `o_rdValid` out 1: `o_readData` is valid this cycle.
- `o_misaligned` out 1: pulse, misaligned or illegal access.
- `o_fault` out 1: pulse, bus error or timeout.
- `o_bus_req`, `o_bus_we` out 1: bus request and write strobe.
- `o_bus_addr` out ADDR_W: word-aligned address, bits [1:0] = 0.
- `o_bus_wdata` out 32: store data on the bus.
- `o_bus_be` out 4: byte enables.
- `i_bus_ack`, `i_bus_err` in 1: bus response.
- `i_bus_rdata` in 32: bus read data.

## Operation
- **Access.** An access is `i_valid & (i_memRead | i_memWrite)`. If both strobes are set, the access is treated as a load.
- **Alignment.** An access is aligned when: byte always; half needs addr[0]=0; word needs addr[1:0]=0. Size 11 is always misaligned.
- **FSM states:** IDLE, BUS, DONE.
- **IDLE, aligned access.** Register address, byte enables, write data and the load attributes (lane, size, unsigned). Go to BUS. Clear the timeout counter.
- **IDLE, misaligned access.** Go to DONE with the misaligned flag set. No bus request is issued.
- **BUS.** `o_bus_req`=1 with stable registered fields until the ack.
  - `i_bus_ack`=1 and `i_bus_err`=0: capture the extended load data, go to DONE.
  - `i_bus_err`=1: take priority over ack, set the fault flag, go to DONE.
  - Counter reaches `TIMEOUT_CYCLES` (when nonzero): set the fault flag, go to DONE.
- **DONE.** Go to IDLE unconditionally. Inputs are ignored because they still carry the same instruction.
- **Bus fields.**
  - Store enables: byte `0001<<a[1:0]`, half `0011<<a[1:0]`, word `1111`.
  - Store data: byte replicated ×4, half replicated ×2.
- **Load extraction.** Select byte lane a[1:0] or half lane a[1]. Sign-extend unless `i_unsigned`.
- **Faulting or misaligned load.** `o_readData`=0.
- **Outputs in DONE.** `o_rdValid`=1 for loads only. `o_misaligned` or `o_fault` pulses exactly this cycle.
- **`o_stall`.** Equals (IDLE & accepted access) | BUS. It is 0 in DONE.
- **`o_PCSrc`.** Combinational, equal to `i_valid & (i_jump | (i_branch & cond))`.
  - 000 `i_zero`, 001 `!i_zero`.
  - 100 `i_lt`, 101 `!i_lt`.
  - 110 `i_ltu`, 111 `!i_ltu`.
  - 010 and 011: 0.
  - Independent of FSM state.
- **Stray responses.** `i_bus_ack` or `i_bus_err` outside BUS is ignored.

## Timing
- **Reset values.** State IDLE. `o_stall`, `o_bus_req`, `o_bus_we`, `o_rdValid`, `o_misaligned`, `o_fault`, `o_PCSrc` (given `i_valid`=0) all 0. `o_readData`, `o_bus_addr`, `o_bus_wdata`, `o_bus_be` all 0.
- **Reset mid-transaction.** Asserting `i_reset_n` low drops `o_bus_req` and returns to IDLE asynchronously. The transaction is abandoned.
- **Latency.** Accept in cycle 0, BUS from cycle 1, DONE in the cycle after the ack.
  - Ack in the first BUS cycle gives `o_stall` for exactly 2 cycles and `o_rdValid` in cycle 2.
  - Each wait cycle adds 1.
- **Misaligned.** `o_stall` for 1 cycle, `o_misaligned` in cycle 1.
- **Timeout.** Fires in the `TIMEOUT_CYCLES`-th BUS cycle without ack. DONE follows in the next cycle.
- **Back-to-back.** A new access is accepted in the IDLE cycle immediately after DONE. Throughput is therefore at most one access every 3 cycles.

## Test plan
- **Aligned word load.** Load word at 0x100, ack after 0 waits, rdata 0xDEADBEEF -> `o_bus_be`=1111, `o_stall` 2 cycles, `o_readData`=0xDEADBEEF with `o_rdValid` in cycle 2.
- **Byte and half loads.** Load byte at 0x103, rdata 0x80FF_0000, signed -> 0xFFFFFF80; unsigned -> 0x00000080. Load half at 0x102, signed -> 0xFFFF80FF.
- **Half store.** Store half 0x1234ABCD to 0x102 -> `o_bus_be`=1100, `o_bus_wdata`=0xABCDABCD, `o_bus_we`=1, `o_rdValid` stays 0.
- **Misaligned and error.** Word load at 0x101 -> no `o_bus_req`, `o_misaligned` pulse, `o_readData`=0. `i_bus_err` in BUS -> `o_fault` pulse, DONE next cycle.
- **Timeout and reset.** `TIMEOUT_CYCLES`=4 with no ack -> `o_fault` after 4 BUS cycles. Reset during BUS -> `o_bus_req`=0 immediately, next access proceeds normally.
- **Branches.** Sweep `i_brCond` × flags × `i_valid`, plus `i_jump` -> `o_PCSrc` matches the table. With BEQ, `i_zero`=1, `i_valid`=0 -> `o_PCSrc`=0.
